// File: rtl/z_run_pkg.sv
// z_run_pkg: shared state, record type and default sizes for the z run-length encoder
package z_run_pkg;
  localparam int DEF_LEN_W = 8;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_DROP_W = 8;
  typedef enum logic {IDLE, RUN} state_t;
  typedef struct packed {
    logic [DEF_LEN_W-1:0] len;
    logic sat;
  } record_t;
endpackage

// File: rtl/z_run_fifo.sv
// z_run_fifo: sync FIFO with wrap-bit pointers; a push while full is accepted only alongside a pop
module z_run_fifo #(
  parameter int W = 9,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic wr_en, rd_en;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/z_run_encoder.sv
// z_run_encoder: measures high runs of z over valid samples and queues {len, sat} records
module z_run_encoder
  import z_run_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int DROP_W = DEF_DROP_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic              z,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LEN_W-1:0]  out_len,
  output logic              out_sat,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              busy
);
  localparam logic [LEN_W-1:0] MAX = '1;
  state_t state, state_nx;
  logic [LEN_W-1:0] len, len_nx;
  logic sat, sat_nx, push, pop, full, empty;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      len <= '0;
      sat <= 1'b0;
    end else if (in_valid) begin
      state <= state_nx;
      len <= len_nx;
      sat <= sat_nx;
    end
  always_comb begin
    state_nx = state;
    len_nx = len;
    sat_nx = sat;
    if (state == IDLE) begin
      if (z) begin
        state_nx = RUN;
        len_nx = LEN_W'(1);
        sat_nx = 1'b0;
      end
    end else if (z) begin
      len_nx = (len == MAX) ? MAX : len + 1'b1;
      sat_nx = sat || (len_nx == MAX);
    end else begin
      state_nx = IDLE;
    end
  end
  assign push = in_valid && state == RUN && !z;
  assign pop = out_valid && out_ready;
  assign out_valid = !empty;
  assign busy = state == RUN;
  // a record is lost only when the FIFO is full and nothing leaves on the same edge
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) drop_cnt <= '0;
    else if (push && full && !pop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
  z_run_fifo #(.W(LEN_W + 1), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .resetn(resetn),
    .push(push),
    .pop(pop),
    .din({len, sat}),
    .full(full),
    .empty(empty),
    .dout({out_len, out_sat})
  );
endmodule

// File: tb/tb_z_run_encoder.sv
// tb_z_run_encoder: directed scenarios for the z run-length encoder
module tb_z_run_encoder;
  logic clk = 1'b0, resetn = 1'b0, in_valid = 1'b0, z = 1'b0, out_ready = 1'b0;
  logic out_valid, out_sat, busy;
  logic [7:0] out_len, drop_cnt;
  int chk = 0, fails = 0;
  z_run_encoder #(.LEN_W(8), .DEPTH(4), .DROP_W(8)) dut (
    .clk(clk),
    .resetn(resetn),
    .in_valid(in_valid),
    .z(z),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_len(out_len),
    .out_sat(out_sat),
    .drop_cnt(drop_cnt),
    .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic smp(input logic v, input logic zz);
    in_valid = v;
    z = zz;
    tick();
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) smp(1'b1, 1'b1);
    smp(1'b1, 1'b0);
  endtask
  task automatic test_reset();
    resetn = 1'b0;
    #12;
    chk++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
    chk++; if (out_len !== 8'd0) begin fails++; $display("FAIL reset_len got %0d exp 0", out_len); end
    chk++; if (out_sat !== 1'b0) begin fails++; $display("FAIL reset_sat got %0b exp 0", out_sat); end
    chk++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b exp 0", busy); end
    chk++; if (drop_cnt !== 8'd0) begin fails++; $display("FAIL reset_drop got %0d exp 0", drop_cnt); end
    @(negedge clk);
    resetn = 1'b1;
  endtask
  task automatic test_basic();
    logic [4:0] zs;
    int bc;
    zs = 5'b01110;
    bc = 0;
    for (int i = 4; i >= 0; i--) begin
      smp(1'b1, zs[i]);
      if (busy) bc++;
      if (i == 1) begin
        chk++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid got %0b exp 0", out_valid); end
      end
    end
    chk++; if (bc != 3) begin fails++; $display("FAIL basic_busy_cycles got %0d exp 3", bc); end
    chk++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %0b exp 1", out_valid); end
    chk++; if (out_len !== 8'd3) begin fails++; $display("FAIL basic_len got %0d exp 3", out_len); end
    chk++; if (out_sat !== 1'b0) begin fails++; $display("FAIL basic_sat got %0b exp 0", out_sat); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_drained got %0b exp 0", out_valid); end
  endtask
  task automatic test_gaps();
    smp(1'b1, 1'b1);
    smp(1'b1, 1'b1);
    smp(1'b0, 1'b0);
    smp(1'b0, 1'b0);
    chk++; if (busy !== 1'b1) begin fails++; $display("FAIL gap_busy got %0b exp 1", busy); end
    chk++; if (out_valid !== 1'b0) begin fails++; $display("FAIL gap_valid got %0b exp 0", out_valid); end
    smp(1'b1, 1'b1);
    smp(1'b1, 1'b0);
    chk++; if (out_len !== 8'd3) begin fails++; $display("FAIL gap_len got %0d exp 3", out_len); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask
  task automatic test_sat();
    run(300);
    chk++; if (out_len !== 8'd255) begin fails++; $display("FAIL sat_len got %0d exp 255", out_len); end
    chk++; if (out_sat !== 1'b1) begin fails++; $display("FAIL sat_flag got %0b exp 1", out_sat); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    run(2);
    chk++; if (out_len !== 8'd2) begin fails++; $display("FAIL sat_next_len got %0d exp 2", out_len); end
    chk++; if (out_sat !== 1'b0) begin fails++; $display("FAIL sat_next_flag got %0b exp 0", out_sat); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask
  task automatic test_overflow();
    for (int r = 0; r < 6; r++) begin
      run(1);
      chk++; if (out_valid !== 1'b1 || out_len !== 8'd1) begin fails++; $display("FAIL ovf_head got v=%0b len=%0d exp v=1 len=1", out_valid, out_len); end
    end
    chk++; if (drop_cnt !== 8'd2) begin fails++; $display("FAIL ovf_drop got %0d exp 2", drop_cnt); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk++; if (out_valid !== 1'b1 || out_len !== 8'd1) begin fails++; $display("FAIL ovf_drain got v=%0b len=%0d exp v=1 len=1", out_valid, out_len); end
      tick();
    end
    out_ready = 1'b0;
    chk++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ovf_empty got %0b exp 0", out_valid); end
  endtask
  task automatic test_back_to_back();
    for (int k = 1; k <= 4; k++) run(k);
    for (int i = 0; i < 5; i++) smp(1'b1, 1'b1);
    out_ready = 1'b1;
    smp(1'b1, 1'b0);
    chk++; if (drop_cnt !== 8'd2) begin fails++; $display("FAIL b2b_drop got %0d exp 2", drop_cnt); end
    in_valid = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      chk++; if (out_valid !== 1'b1 || out_len !== 8'(k)) begin fails++; $display("FAIL b2b_order got v=%0b len=%0d exp v=1 len=%0d", out_valid, out_len, k); end
      tick();
    end
    out_ready = 1'b0;
    for (int k = 6; k <= 15; k++) begin
      run(k);
      chk++; if (out_valid !== 1'b1 || out_len !== 8'(k)) begin fails++; $display("FAIL wrap_order got v=%0b len=%0d exp v=1 len=%0d", out_valid, out_len, k); end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    chk++; if (out_valid !== 1'b0) begin fails++; $display("FAIL wrap_empty got %0b exp 0", out_valid); end
  endtask
  task automatic test_async_reset();
    run(1);
    run(2);
    for (int i = 0; i < 5; i++) smp(1'b1, 1'b1);
    in_valid = 1'b0;
    chk++; if (busy !== 1'b1 || out_len !== 8'd1) begin fails++; $display("FAIL ar_pre got busy=%0b len=%0d exp busy=1 len=1", busy, out_len); end
    #2;
    resetn = 1'b0;
    #1;
    chk++; if (out_valid !== 1'b0 || out_len !== 8'd0 || out_sat !== 1'b0) begin fails++; $display("FAIL ar_out got v=%0b len=%0d sat=%0b exp 0 0 0", out_valid, out_len, out_sat); end
    chk++; if (busy !== 1'b0 || drop_cnt !== 8'd0) begin fails++; $display("FAIL ar_state got busy=%0b drop=%0d exp 0 0", busy, drop_cnt); end
    @(negedge clk);
    resetn = 1'b1;
    run(2);
    chk++; if (out_valid !== 1'b1 || out_len !== 8'd2) begin fails++; $display("FAIL ar_rec got v=%0b len=%0d exp v=1 len=2", out_valid, out_len); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ar_single got %0b exp 0", out_valid); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_sat();
    test_overflow();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", chk, fails);
    $finish;
  end
endmodule
